// File: rtl/decode_stage_if.sv
// Bundle between the IF/ID register, the WB stage, the hazard unit and the
// decode stage. master = surrounding pipeline, slave = decode_stage.
interface decode_stage_if #(
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned REG_ADDR_W = 5
);
    // IF/ID inputs
    logic [WORD_SIZE-1:0]  InstrD;
    logic [WORD_SIZE-1:0]  PCD;
    logic [WORD_SIZE-1:0]  PCPlus4D;
    // Write-back port
    logic                  RegWriteW;
    logic [REG_ADDR_W-1:0] RdW;
    logic [WORD_SIZE-1:0]  ResultW;
    // Hazard unit
    logic                  FlushE;
    logic [REG_ADDR_W-1:0] Rs1D;
    logic [REG_ADDR_W-1:0] Rs2D;
    // ID/EX register outputs
    logic                  RegWriteE;
    logic [1:0]            ResultSrcE;
    logic                  MemWriteE;
    logic                  JumpE;
    logic                  BranchE;
    logic [2:0]            ALUControlE;
    logic                  ALUSrcE;
    logic [WORD_SIZE-1:0]  RD1E;
    logic [WORD_SIZE-1:0]  RD2E;
    logic [REG_ADDR_W-1:0] Rs1E;
    logic [REG_ADDR_W-1:0] Rs2E;
    logic [REG_ADDR_W-1:0] RdE;
    logic [WORD_SIZE-1:0]  ImmExtE;
    logic [WORD_SIZE-1:0]  PCE;
    logic [WORD_SIZE-1:0]  PCPlus4E;

    modport master (
        output InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
        input  Rs1D, Rs2D, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
               ALUControlE, ALUSrcE, RD1E, RD2E, Rs1E, Rs2E, RdE, ImmExtE,
               PCE, PCPlus4E
    );

    modport slave (
        input  InstrD, PCD, PCPlus4D, RegWriteW, RdW, ResultW, FlushE,
        output Rs1D, Rs2D, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
               ALUControlE, ALUSrcE, RD1E, RD2E, Rs1E, Rs2E, RdE, ImmExtE,
               PCE, PCPlus4E
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I-subset decode stage: main/ALU decoders, immediate extender, 32x32
// register file (written from WB) and the ID/EX pipeline register.
// Optional macro REGFILE_BYPASS_EN: forward a same-cycle WB write to the
// read ports; without it reads return the pre-write register value.
module decode_stage #(
    parameter int unsigned WORD_SIZE  = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);
    localparam int unsigned NumRegs = 2 ** REG_ADDR_W;

    localparam logic [6:0] OpLw   = 7'b0000011;
    localparam logic [6:0] OpSw   = 7'b0100011;
    localparam logic [6:0] OpRtyp = 7'b0110011;
    localparam logic [6:0] OpBeq  = 7'b1100011;
    localparam logic [6:0] OpIalu = 7'b0010011;
    localparam logic [6:0] OpJal  = 7'b1101111;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    logic [WORD_SIZE-1:0]  instr;
    logic [6:0]            op;
    logic [2:0]            funct3;
    logic                  funct7b5;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;

    logic                  regWriteD;
    logic [1:0]            resultSrcD;
    logic                  memWriteD;
    logic                  jumpD;
    logic                  branchD;
    logic                  aluSrcD;
    logic [1:0]            immSrcD;
    logic [1:0]            aluOpD;
    logic [2:0]            aluControlD;
    logic [WORD_SIZE-1:0]  immExtD;
    logic [WORD_SIZE-1:0]  rd1D;
    logic [WORD_SIZE-1:0]  rd2D;

    logic [WORD_SIZE-1:0]  regs [NumRegs];

    assign instr    = bus.InstrD;
    assign op       = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7b5 = instr[30];
    assign rs1      = instr[19:15];
    assign rs2      = instr[24:20];
    assign rd       = instr[11:7];

    assign bus.Rs1D = rs1;
    assign bus.Rs2D = rs2;

    // Main decoder: opcode to control fields; unknown opcodes decode to all-zero controls
    always_comb begin
        regWriteD  = 1'b0;
        immSrcD    = 2'b00;
        aluSrcD    = 1'b0;
        memWriteD  = 1'b0;
        resultSrcD = 2'b00;
        branchD    = 1'b0;
        aluOpD     = 2'b00;
        jumpD      = 1'b0;
        case (op)
            OpLw: begin
                regWriteD  = 1'b1;
                aluSrcD    = 1'b1;
                resultSrcD = 2'b01;
            end
            OpSw: begin
                immSrcD   = 2'b01;
                aluSrcD   = 1'b1;
                memWriteD = 1'b1;
            end
            OpRtyp: begin
                regWriteD = 1'b1;
                aluOpD    = 2'b10;
            end
            OpBeq: begin
                immSrcD = 2'b10;
                branchD = 1'b1;
                aluOpD  = 2'b01;
            end
            OpIalu: begin
                regWriteD = 1'b1;
                aluSrcD   = 1'b1;
                aluOpD    = 2'b10;
            end
            OpJal: begin
                regWriteD  = 1'b1;
                immSrcD    = 2'b11;
                resultSrcD = 2'b10;
                jumpD      = 1'b1;
            end
            default: ;
        endcase
    end

    // ALU decoder: ALUOp plus funct3/funct7 select the ALU operation
    always_comb begin
        aluControlD = AluAdd;
        case (aluOpD)
            2'b01: aluControlD = AluSub;
            2'b10: begin
                case (funct3)
                    3'b000:  aluControlD = ({op[5], funct7b5} == 2'b11) ? AluSub : AluAdd;
                    3'b010:  aluControlD = AluSlt;
                    3'b110:  aluControlD = AluOr;
                    3'b111:  aluControlD = AluAnd;
                    default: aluControlD = AluAdd;
                endcase
            end
            default: aluControlD = AluAdd;
        endcase
    end

    // Immediate extender for I/S/B/J formats
    always_comb begin
        immExtD = '0;
        case (immSrcD)
            2'b00: immExtD = {{20{instr[31]}}, instr[31:20]};
            2'b01: immExtD = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            2'b10: immExtD = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            2'b11: immExtD = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: immExtD = '0;
        endcase
    end

    // Register file write port; x0 is never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned k = 0; k < NumRegs; k++) begin
                regs[k] <= '0;
            end
        end else if (bus.RegWriteW && (bus.RdW != '0)) begin
            regs[bus.RdW] <= bus.ResultW;
        end
    end

    // Register file read ports; x0 reads zero
    always_comb begin
        rd1D = (rs1 == '0) ? '0 : regs[rs1];
        rd2D = (rs2 == '0) ? '0 : regs[rs2];
`ifdef REGFILE_BYPASS_EN
        if (bus.RegWriteW && (bus.RdW != '0) && (bus.RdW == rs1)) begin
            rd1D = bus.ResultW;
        end
        if (bus.RegWriteW && (bus.RdW != '0) && (bus.RdW == rs2)) begin
            rd2D = bus.ResultW;
        end
`endif
    end

    // ID/EX pipeline register; flush loads a NOP bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst || bus.FlushE) begin
            bus.RegWriteE   <= 1'b0;
            bus.ResultSrcE  <= 2'b00;
            bus.MemWriteE   <= 1'b0;
            bus.JumpE       <= 1'b0;
            bus.BranchE     <= 1'b0;
            bus.ALUControlE <= 3'b000;
            bus.ALUSrcE     <= 1'b0;
            bus.RD1E        <= '0;
            bus.RD2E        <= '0;
            bus.Rs1E        <= '0;
            bus.Rs2E        <= '0;
            bus.RdE         <= '0;
            bus.ImmExtE     <= '0;
            bus.PCE         <= '0;
            bus.PCPlus4E    <= '0;
        end else begin
            bus.RegWriteE   <= regWriteD;
            bus.ResultSrcE  <= resultSrcD;
            bus.MemWriteE   <= memWriteD;
            bus.JumpE       <= jumpD;
            bus.BranchE     <= branchD;
            bus.ALUControlE <= aluControlD;
            bus.ALUSrcE     <= aluSrcD;
            bus.RD1E        <= rd1D;
            bus.RD2E        <= rd2D;
            bus.Rs1E        <= rs1;
            bus.Rs2E        <= rs2;
            bus.RdE         <= rd;
            bus.ImmExtE     <= immExtD;
            bus.PCE         <= bus.PCD;
            bus.PCPlus4E    <= bus.PCPlus4D;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vector table, reset
// sequence, then randomized instructions against a reference model.
module tb_decode_stage;
`ifdef REGFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    typedef struct packed {
        logic        regWrite;
        logic [1:0]  resultSrc;
        logic        memWrite;
        logic        jump;
        logic        branch;
        logic [2:0]  aluCtl;
        logic        aluSrc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [31:0] pcp4;
    } eBus_t;

    typedef struct {
        logic [31:0] instr;
        logic        flush;
        logic        wbEn;
        logic [4:0]  wbRd;
        logic [31:0] wbData;
        eBus_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;
    logic [31:0] model [32];
    eBus_t dutE;
    vec_t  vecs [11];

    decode_stage_if #(.WORD_SIZE(32), .REG_ADDR_W(5)) bus ();

    decode_stage #(.WORD_SIZE(32), .REG_ADDR_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign dutE = {bus.RegWriteE, bus.ResultSrcE, bus.MemWriteE, bus.JumpE, bus.BranchE,
                   bus.ALUControlE, bus.ALUSrcE, bus.RD1E, bus.RD2E, bus.Rs1E, bus.Rs2E,
                   bus.RdE, bus.ImmExtE, bus.PCE, bus.PCPlus4E};

    task automatic checkE(input string name, input eBus_t exp);
        checks++;
        if (dutE === exp) passes++;
        else $display("FAIL %s: got %h want %h", name, dutE, exp);
    endtask

    task automatic checkRs(input string name, input logic [4:0] r1, input logic [4:0] r2);
        checks++;
        if (bus.Rs1D === r1 && bus.Rs2D === r2) passes++;
        else $display("FAIL %s: got rs1=%0d rs2=%0d want rs1=%0d rs2=%0d",
                      name, bus.Rs1D, bus.Rs2D, r1, r2);
    endtask

    function automatic eBus_t mk(input logic rw, input logic [1:0] rs, input logic mw,
                                 input logic j, input logic b, input logic [2:0] alu,
                                 input logic as, input logic [31:0] d1, input logic [31:0] d2,
                                 input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                                 input logic [31:0] imm);
        eBus_t e;
        e = '0;
        e.regWrite = rw; e.resultSrc = rs; e.memWrite = mw; e.jump = j; e.branch = b;
        e.aluCtl = alu; e.aluSrc = as; e.rd1 = d1; e.rd2 = d2;
        e.rs1 = r1; e.rs2 = r2; e.rd = rd; e.imm = imm;
        return e;
    endfunction

    function automatic logic [31:0] immI(input logic [31:0] i);
        return 32'($signed(i) >>> 20);
    endfunction

    function automatic logic [31:0] immS(input logic [31:0] i);
        int v;
        v = int'($signed(i) >>> 25) * 32 + int'(i[11:7]);
        return 32'(v);
    endfunction

    function automatic logic [31:0] immB(input logic [31:0] i);
        int v;
        v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
        return 32'(v);
    endfunction

    function automatic logic [31:0] immJ(input logic [31:0] i);
        int v;
        v = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
            + int'(i[30:21]) * 2;
        return 32'(v);
    endfunction

    function automatic logic [2:0] aluFn(input logic [2:0] f3, input logic isSub);
        case (f3)
            3'd0:    return isSub ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [31:0] readReg(input logic [4:0] r, input logic wbEn,
                                            input logic [4:0] wbRd, input logic [31:0] wbData);
        if (r == 5'd0) return 32'd0;
        if (Bypass && wbEn && wbRd == r) return wbData;
        return model[r];
    endfunction

    function automatic eBus_t refModel(input logic [31:0] i, input logic [31:0] pc,
                                       input logic [31:0] pcp4, input logic flush,
                                       input logic wbEn, input logic [4:0] wbRd,
                                       input logic [31:0] wbData);
        eBus_t e;
        e = '0;
        if (flush) return e;
        e.rs1 = i[19:15]; e.rs2 = i[24:20]; e.rd = i[11:7];
        e.pc = pc; e.pcp4 = pcp4;
        e.rd1 = readReg(e.rs1, wbEn, wbRd, wbData);
        e.rd2 = readReg(e.rs2, wbEn, wbRd, wbData);
        e.imm = immI(i);
        case (i[6:0])
            7'b0000011: begin e.regWrite = 1; e.aluSrc = 1; e.resultSrc = 2'd1; end
            7'b0100011: begin e.memWrite = 1; e.aluSrc = 1; e.imm = immS(i); end
            7'b0110011: begin e.regWrite = 1; e.aluCtl = aluFn(i[14:12], i[30]); end
            7'b1100011: begin e.branch = 1; e.aluCtl = 3'b001; e.imm = immB(i); end
            7'b0010011: begin e.regWrite = 1; e.aluSrc = 1; e.aluCtl = aluFn(i[14:12], 1'b0); end
            7'b1101111: begin e.regWrite = 1; e.jump = 1; e.resultSrc = 2'd2; e.imm = immJ(i); end
            default: ;
        endcase
        return e;
    endfunction

    task automatic drive(input logic [31:0] i, input logic [31:0] pc, input logic flush,
                         input logic wbEn, input logic [4:0] wbRd, input logic [31:0] wbData);
        bus.InstrD = i; bus.PCD = pc; bus.PCPlus4D = pc + 32'd4;
        bus.FlushE = flush; bus.RegWriteW = wbEn; bus.RdW = wbRd; bus.ResultW = wbData;
    endtask

    initial begin
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] wbData;
        logic [4:0]  wbRd;
        logic        wbEn;
        logic        flush;
        logic [6:0]  ops [6];
        eBus_t       exp;

        for (int k = 0; k < 32; k++) model[k] = 32'd0;
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b1100011; ops[4] = 7'b0010011; ops[5] = 7'b1101111;

        // instr, flush, wbEn, wbRd, wbData, expected
        vecs[0]  = '{32'h0000_0000, 0, 1, 5'd3, 32'hDEAD_BEEF, mk(0,0,0,0,0,0,0, 0, 0, 0, 0, 0, 0)};
        vecs[1]  = '{32'h0001_80B3, 0, 0, 5'd0, 32'h0, mk(1,0,0,0,0,0,0, 32'hDEAD_BEEF, 0, 3, 0, 1, 0)};
        vecs[2]  = '{32'hFFC0_A103, 0, 0, 5'd0, 32'h0, mk(1,1,0,0,0,0,1, 0, 0, 1, 28, 2, 32'hFFFF_FFFC)};
        vecs[3]  = '{32'hFFC0_A103, 1, 0, 5'd0, 32'h0, '0};
        vecs[4]  = '{32'hFE20_8CE3, 0, 0, 5'd0, 32'h0, mk(0,0,0,0,1,1,0, 0, 0, 1, 2, 25, 32'hFFFF_FFF8)};
        vecs[5]  = '{32'h0100_00EF, 0, 0, 5'd0, 32'h0, mk(1,2,0,1,0,0,0, 0, 0, 0, 16, 1, 32'h10)};
        vecs[6]  = '{32'h0000_0000, 0, 1, 5'd0, 32'hFFFF_FFFF, mk(0,0,0,0,0,0,0, 0, 0, 0, 0, 0, 0)};
        vecs[7]  = '{32'h0000_00B3, 0, 0, 5'd0, 32'h0, mk(1,0,0,0,0,0,0, 0, 0, 0, 0, 1, 0)};
        vecs[8]  = '{32'h0000_0000, 0, 1, 5'd7, 32'h11, mk(0,0,0,0,0,0,0, 0, 0, 0, 0, 0, 0)};
        vecs[9]  = '{32'h4073_8433, 0, 1, 5'd7, 32'h55,
                     mk(1,0,0,0,0,1,0, Bypass ? 32'h55 : 32'h11, Bypass ? 32'h55 : 32'h11,
                        7, 7, 8, 32'h407)};
        vecs[10] = '{32'h4073_8433, 0, 0, 5'd0, 32'h0, mk(1,0,0,0,0,1,0, 32'h55, 32'h55, 7, 7, 8, 32'h407)};

        drive(32'h0, 32'h0, 0, 0, 5'd0, 32'h0);
        #2;
        checkE("reset_state", '0);
        @(negedge clk);
        rst = 1'b0;

        // Directed vector table
        for (int v = 0; v < 11; v++) begin
            pc = 32'h100 + 32'(v) * 32'd4;
            exp = vecs[v].exp;
            if (!vecs[v].flush) begin
                exp.pc = pc;
                exp.pcp4 = pc + 32'd4;
            end
            drive(vecs[v].instr, pc, vecs[v].flush, vecs[v].wbEn, vecs[v].wbRd, vecs[v].wbData);
            #1;
            if (!vecs[v].flush) checkRs($sformatf("vec%0d_rsD", v), exp.rs1, exp.rs2);
            @(posedge clk);
            #1;
            checkE($sformatf("vec%0d", v), exp);
        end

        // Mid-run asynchronous reset after writing x5
        drive(32'h0001_80B3, 32'h200, 0, 1, 5'd5, 32'h1234);
        @(posedge clk);
        #1;
        drive(32'h0001_80B3, 32'h204, 0, 0, 5'd0, 32'h0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkE("async_reset", '0);
        @(negedge clk);
        rst = 1'b0;
        drive(32'h0052_80B3, 32'h300, 0, 0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        exp = mk(1,0,0,0,0,0,0, 0, 0, 5, 5, 1, 32'h5);
        exp.pc = 32'h300; exp.pcp4 = 32'h304;
        checkE("x5_cleared", exp);

        // Randomized stimulus against the reference model
        for (int n = 0; n < 400; n++) begin
            instr = $urandom;
            case ($urandom_range(0, 7))
                6: ;
                7: instr = 32'h0;
                default: instr[6:0] = ops[$urandom_range(0, 5)];
            endcase
            pc     = $urandom & 32'hFFFF_FFFC;
            flush  = ($urandom_range(0, 9) == 0);
            wbEn   = 1'($urandom_range(0, 1));
            wbRd   = ($urandom_range(0, 3) == 0) ? instr[19:15] : 5'($urandom_range(0, 31));
            wbData = $urandom;
            exp = refModel(instr, pc, pc + 32'd4, flush, wbEn, wbRd, wbData);
            drive(instr, pc, flush, wbEn, wbRd, wbData);
            @(posedge clk);
            #1;
            if (wbEn && wbRd != 5'd0) model[wbRd] = wbData;
            checkE($sformatf("rand%0d", n), exp);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Second stage of the 5-stage RV32I-subset pipeline. Consumes the IF/ID register outputs (InstrD, PCD, PCPlus4D) and decodes the instruction into control signals. Reads the 32x32 register file and sign-extends the immediate. Registers everything into the ID/EX pipeline register for the execute stage; it also hosts the register file written back from the WB stage.

Parameters:
WORD_SIZE, 32, datapath/instruction width
REG_ADDR_W, 5, register index width (32 registers)

Ports:
clk  in  1  clock
rst  in  1  reset
InstrD  in  32  instruction from IF/ID
PCD  in  32  PC of InstrD
PCPlus4D  in  32  PCD+4
RegWriteW  in  1  WB write enable
RdW  in  5  WB destination register
ResultW  in  32  WB write data
FlushE  in  1  hazard unit: load bubble into ID/EX
Rs1D  out  5  InstrD[19:15], combinational, for hazard unit
Rs2D  out  5  InstrD[24:20], combinational, for hazard unit
RegWriteE  out  1  registered control
ResultSrcE  out  2  00 ALU, 01 memory, 10 PC+4
MemWriteE  out  1  store enable
JumpE  out  1  jal
BranchE  out  1  beq
ALUControlE  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ALUSrcE  out  1  0 RD2, 1 immediate
RD1E  out  32  rs1 data
RD2E  out  32  rs2 data
Rs1E  out  5  registered rs1 index
Rs2E  out  5  registered rs2 index
RdE  out  5  InstrD[11:7] registered
ImmExtE  out  32  sign-extended immediate
PCE  out  32  registered PCD
PCPlus4E  out  32  registered PCPlus4D

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset, all ID/EX outputs are 0 and all 32 registers are cleared to 0. Reset mid-operation discards in-flight state immediately.
- Latency: one cycle. Values decoded from InstrD in cycle n appear on the *E outputs after the posedge ending cycle n.
- ID/EX update at posedge:
  - FlushE=1: every *E output is loaded with 0, producing a NOP bubble.
  - Otherwise every *E output captures its decoded value.
  - There is no stall input; the E stage is never held.
- Main decoder (opcode InstrD[6:0]); fields are RegWrite/ImmSrc/ALUSrc/MemWrite/ResultSrc/Branch/ALUOp/Jump:
  - 0000011 lw: 1/00/1/0/01/0/00/0
  - 0100011 sw: 0/01/1/1/xx→00/0/00/0
  - 0110011 R-type: 1/xx→00/0/0/00/0/10/0
  - 1100011 beq: 0/10/0/0/00/1/01/0
  - 0010011 I-ALU: 1/00/1/0/00/0/10/0
  - 1101111 jal: 1/11/0/0/10/0/00/1
  - Any other opcode, including all-zero: all controls 0. This gives no architectural side effect.
- ALU decoder:
  - ALUOp 00 → add.
  - ALUOp 01 → sub.
  - ALUOp 10, by funct3:
    - 000: sub if {op[5],funct7[5]}=11, else add.
    - 010: slt.
    - 110: or.
    - 111: and.
    - Other funct3 values: add.
- Immediate (ImmSrc):
  - 00 I: {20{i[31]},i[31:20]}
  - 01 S: {20{i[31]},i[31:25],i[11:7]}
  - 10 B: {20{i[31]},i[7],i[30:25],i[11:8],1'b0}
  - 11 J: {12{i[31]},i[19:12],i[20],i[30:21],1'b0}
- Register file:
  - Two combinational read ports and one write port, written at posedge clk when RegWriteW=1 and RdW≠0.
  - x0 always reads 0, and writes to x0 are ignored.
- Simultaneous WB write and ID read of the same register in the same cycle is governed by the optional feature.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: if RegWriteW=1, RdW≠0 and RdW equals Rs1D (or Rs2D), the read port returns ResultW combinationally. RD1E/RD2E therefore capture the new value at the same edge the register is written.
- Undefined: no bypass. The read returns the pre-write value, and the hazard unit must stall to cover the one-cycle window.

Test Plan:
1. Assert rst mid-run after writing x5=0x1234 → all *E outputs 0; x5 reads 0 after release.
2. WB writes x3=0xDEADBEEF; next cycle InstrD=add x1,x3,x0 (0x000180B3) → RD1E=0xDEADBEEF, RD2E=0, RegWriteE=1, ALUControlE=000, RdE=1.
3. InstrD=lw x2,-4(x1) (0xFFC0A103) → ImmExtE=0xFFFFFFFC, ALUSrcE=1, ResultSrcE=01, RegWriteE=1. Repeat with FlushE=1 → all *E outputs 0.
4. InstrD=beq x1,x2,-8 (0xFE208CE3) → BranchE=1, ALUControlE=001, ImmExtE=0xFFFFFFF8, RegWriteE=0. InstrD=jal x1,+16 (0x010000EF) → JumpE=1, ResultSrcE=10, ImmExtE=0x10.
5. WB writes x0=0xFFFFFFFF → later read of x0 gives 0.
6. Same cycle: WB writes x7=0x55 while InstrD=sub x8,x7,x7 (0x40738433) → RD1E=RD2E=0x55 with REGFILE_BYPASS_EN, old x7 value without; ALUControlE=001 in both.
